csr_rx_queue: RTL and testbench

Parametrised successor of the UART_RX/ADC_RX read-on-clear CSR channel: a HW producer pushes words into a DEPTH-entry queue behind the single CSR holding slot ('data' + 'valid'). SW drains the queue by polling one 32-bit CSR word, and each consuming read advances the queue. Sits between a receive engine (UART RX, ADC, GPI debouncer) and the CSR read mux. The block decouples SW polling latency from burst arrival rate and reports fill level and overflow.

---
 rtl/csr_rx_queue_pkg.sv | 19 +
 rtl/csr_rx_queue_if.sv | 22 ++
 rtl/csr_rx_queue_fifo.sv | 52 +++++
 rtl/csr_rx_queue.sv | 144 ++++++++++++++
 tb/tb_csr_rx_queue.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/csr_rx_queue_pkg.sv
// csr_rx_queue shared types: register image layout and CSR addresses.
// Imported by the interface, queue storage and top block.
package csr_rx_queue_pkg;

  localparam int LVL_W = 6;

  localparam logic [11:0] ADDR_UART_RX_Q = 12'h010;
  localparam logic [11:0] ADDR_ADC_RX_Q  = 12'h014;
  localparam logic [11:0] ADDR_GPI_RX_Q  = 12'h018;

  // DW narrower than 24 is handled by masking data, not here.
  typedef struct packed {
    logic             valid;
    logic             oflow;
    logic [LVL_W-1:0] level;
    logic [23:0]      data;
  } rx_queue_t;

endpackage

// File: rtl/csr_rx_queue_if.sv
// Producer + CSR side signal bundle of csr_rx_queue.
// master: producer/CSR mux side, slave: the queue block.
interface csr_rx_queue_if #(
  parameter int DW = 8
);
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          csr_rd;
  logic          csr_flush;
  logic [31:0]   csr_rdata;
  logic          irq;

  modport master (
    output wr_en, wr_data, csr_rd, csr_flush,
    input  csr_rdata, irq
  );

  modport slave (
    input  wr_en, wr_data, csr_rd, csr_flush,
    output csr_rdata, irq
  );
endinterface

// File: rtl/csr_rx_queue_fifo.sv
// DEPTH x DW queue behind the holding slot: plain flops, async read head.
// Ports: push/pop/flush controls, din, dout (head), full, empty, count.
module csr_rx_queue_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is not reset so it can map onto LUT-RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/csr_rx_queue.sv
// Read-on-clear CSR receive queue: holding slot + DEPTH queue, level/oflow, irq.
// Ports: clk, arst_n, bus (slave). Optional irq: define CSR_RX_QUEUE_IRQ_EN.
module csr_rx_queue
  import csr_rx_queue_pkg::*;
#(
  parameter int DW         = 8,
  parameter int DEPTH      = 16,
  parameter int IRQ_THRESH = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input logic            clk,
  input logic            arst_n,
  csr_rx_queue_if.slave  bus
);

  if (DW < 1 || DW > 24 || DEPTH < 2 || DEPTH > 32 ||
      (1 << AW) != DEPTH || IRQ_THRESH < 1 ||
      IRQ_THRESH > DEPTH + 1) begin : g_bad_cfg
    $error("csr_rx_queue: bad parameters");
  end

  logic          valid_q;
  logic          oflow_q;
  logic [DW-1:0] hold_q;

  logic          push;
  logic          pop;
  logic          hold_ld;
  logic [DW-1:0] hold_d;
  logic          valid_d;
  logic          oflow_set;

  logic [DW-1:0] head;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic [LVL_W-1:0] level;
  logic          rd_take;
  rx_queue_t     img;

  csr_rx_queue_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (push),
    .pop    (pop),
    .flush  (bus.csr_flush),
    .din    (bus.wr_data),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  assign rd_take = bus.csr_rd & valid_q;
  assign level   = LVL_W'(count) + LVL_W'(valid_q);

  // valid=0 always implies an empty queue, so a write with
  // valid=0 can go straight to the holding slot.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    hold_ld   = 1'b0;
    hold_d    = bus.wr_data;
    valid_d   = valid_q;
    oflow_set = 1'b0;
    if (!bus.csr_flush) begin
      unique case (1'b1)
        rd_take && bus.wr_en: begin
          if (!empty) begin
            pop    = 1'b1;
            push   = 1'b1;
            hold_d = head;
          end
          hold_ld = 1'b1;
        end
        rd_take && !bus.wr_en: begin
          if (empty) begin
            valid_d = 1'b0;
          end else begin
            pop     = 1'b1;
            hold_ld = 1'b1;
            hold_d  = head;
          end
        end
        bus.wr_en && !valid_q: begin
          hold_ld = 1'b1;
          valid_d = 1'b1;
        end
        bus.wr_en && valid_q && !bus.csr_rd && !full: begin
          push = 1'b1;
        end
        bus.wr_en && valid_q && !bus.csr_rd && full: begin
          oflow_set = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= 1'b0;
      oflow_q <= 1'b0;
      hold_q  <= '0;
    end else if (bus.csr_flush) begin
      valid_q <= 1'b0;
      oflow_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (hold_ld)        hold_q  <= hold_d;
      if (oflow_set)      oflow_q <= 1'b1;
      else if (bus.csr_rd) oflow_q <= 1'b0;
    end
  end

  always_comb begin
    img       = '0;
    img.valid = valid_q;
    img.oflow = oflow_q;
    img.level = level;
    if (valid_q) img.data[DW-1:0] = hold_q;
  end

  assign bus.csr_rdata = img;

`ifdef CSR_RX_QUEUE_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      irq_q <= 1'b0;
    else
      irq_q <= (level >= LVL_W'(IRQ_THRESH)) | oflow_q;
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_csr_rx_queue.sv
// Directed bench for csr_rx_queue (DW=8, DEPTH=16, IRQ_THRESH=8).
// Vector table for the basic read path, hand sequences for corner cases.
module tb_csr_rx_queue;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int IRQ_THRESH = 8;
`ifdef CSR_RX_QUEUE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  csr_rx_queue_if #(.DW(DW)) bus ();

  csr_rx_queue #(
    .DW         (DW),
    .DEPTH      (DEPTH),
    .IRQ_THRESH (IRQ_THRESH)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [7:0]  data;
    logic        rd;
    logic        fl;
    logic [31:0] exp_img;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic wr, input logic [7:0] d,
                     input logic rd, input logic fl);
    bus.wr_en     = wr;
    bus.wr_data   = d;
    bus.csr_rd    = rd;
    bus.csr_flush = fl;
    @(posedge clk);
    #1;
    bus.wr_en     = 1'b0;
    bus.csr_rd    = 1'b0;
    bus.csr_flush = 1'b0;
  endtask

  function automatic logic [31:0] img(input logic v, input logic o,
                                      input int lvl, input int d);
    return {v, o, 6'(lvl), 16'h0, 8'(d)};
  endfunction

  initial begin
    bus.wr_en     = 1'b0;
    bus.wr_data   = '0;
    bus.csr_rd    = 1'b0;
    bus.csr_flush = 1'b0;

    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b1, 8'hA5, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h8100_00A5, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 32'h0000_0000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_img", bus.csr_rdata, 32'h0);
    chk("reset_irq", {31'b0, bus.irq}, 32'h0);
    arst_n = 1'b1;

    foreach (vecs[i]) begin
      chk($sformatf("vec%0d_img", i), bus.csr_rdata, vecs[i].exp_img);
      chk($sformatf("vec%0d_irq", i), {31'b0, bus.irq},
          {31'b0, vecs[i].exp_irq});
      cyc(vecs[i].wr, vecs[i].data, vecs[i].rd, vecs[i].fl);
    end

    // Burst to full, overflow, then ordered drain.
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("burst_full", bus.csr_rdata, 32'h9100_0000);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    chk("burst_oflow", bus.csr_rdata, 32'hD100_0000);
    for (int i = 0; i <= DEPTH; i++) begin
      chk($sformatf("drain%0d", i), bus.csr_rdata,
          img(1'b1, i == 0, DEPTH + 1 - i, i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", bus.csr_rdata, 32'h0);

    // Sustained write+read with one word held.
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) begin
      chk($sformatf("stream%0d", k), bus.csr_rdata,
          img(1'b1, 1'b0, 1, k));
      cyc(1'b1, 8'(k + 1), 1'b1, 1'b0);
    end
    chk("stream_last", bus.csr_rdata, 32'h8100_0064);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_empty", bus.csr_rdata, 32'h0);

    // Simultaneous write+read when full.
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("full_pre", bus.csr_rdata, 32'h9100_0000);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("full_wr_rd", bus.csr_rdata, 32'h9100_0001);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush_full", bus.csr_rdata, 32'h0);

    // Flush beats a concurrent write.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(32 + i), 1'b0, 1'b0);
    chk("lvl5", bus.csr_rdata, 32'h8500_0020);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    chk("flush_wr", bus.csr_rdata, 32'h0);
    cyc(1'b1, 8'h30, 1'b0, 1'b0);
    chk("post_flush", bus.csr_rdata, 32'h8100_0030);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_flush_rd", bus.csr_rdata, 32'h0);

    // irq threshold timing.
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("irq_lvl7", {31'b0, bus.irq}, 32'h0);
    cyc(1'b1, 8'h07, 1'b0, 1'b0);
    chk("irq_lvl8_n", {31'b0, bus.irq}, 32'h0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("irq_lvl8_n1", {31'b0, bus.irq}, {31'b0, IRQ_ON});
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("irq_rd_n", {31'b0, bus.irq}, {31'b0, IRQ_ON});
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("irq_rd_n1", {31'b0, bus.irq}, 32'h0);
    chk("irq_img", bus.csr_rdata, 32'h8700_0001);

    // Async reset mid-burst.
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    #2;
    arst_n = 1'b0;
    #1;
    chk("rst_async", bus.csr_rdata, 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_after", bus.csr_rdata, 32'h0);
    chk("rst_irq", {31'b0, bus.irq}, 32'h0);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("rst_reuse", bus.csr_rdata, 32'h8100_003C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
